master_arbiter: RTL and testbench
=================================

MASTER_ARBITER -- requirements
Module: master_arbiter

Interface
REQ-001 SHALL have parameter MASTER_COUNT, default 2: number of requesting masters, range 2..8.
REQ-002 SHALL have parameter SLAVE_ID_WIDTH, default 2: slave select width; id 0 = no_slave.
REQ-003 SHALL have parameter MAX_HOLD, default 1024: maximum grant tenure in cycles, used only under ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port rstN  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req  input  MASTER_COUNT  per-master bus request, level-held until the transfer is done.
REQ-007 SHALL have port req_slave  input  MASTER_COUNT x SLAVE_ID_WIDTH  per-master target slave id.
REQ-008 SHALL have port grant  output  MASTER_COUNT  one-hot grant, all-zero when idle.
REQ-009 SHALL have port grant_id  output  $clog2(MASTER_COUNT)  index of the granted master, 0 when idle.
REQ-010 SHALL have port slave_sel  output  SLAVE_ID_WIDTH  latched target of the granted master, 0 when idle.
REQ-011 SHALL have port bus_busy  output  1  high whenever any grant is high.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN.

Function
REQ-013 SHALL implement states IDLE, GRANT and RELEASE, all registered.
REQ-014 A master SHALL be eligible only when req[i]=1 and req_slave[i]!=0; requests targeting no_slave SHALL be ignored.
REQ-015 In IDLE, at an edge with at least one eligible master, SHALL select the first eligible index at or after rr_ptr (wrapping modulo MASTER_COUNT) and enter GRANT.
REQ-016 Grant latency SHALL be one cycle: req sampled at edge k gives grant, grant_id, slave_sel and bus_busy valid after edge k.
REQ-017 slave_sel SHALL be captured at grant time and held constant through GRANT, even if req_slave of the granted master changes.
REQ-018 In GRANT, an edge sampling req[grant_id]=0 SHALL enter RELEASE and set rr_ptr to (grant_id+1) mod MASTER_COUNT.
REQ-019 In GRANT, requests from other masters SHALL NOT preempt the current grant.
REQ-020 RELEASE SHALL last exactly one cycle with all outputs 0 (bus turnaround) and then return to IDLE unconditionally.
REQ-021 The minimum gap between consecutive grants SHALL be 2 cycles with grant low.
REQ-022 With simultaneous eligible requests, rotation SHALL guarantee each requester a grant within MASTER_COUNT tenures.
REQ-023 At most one grant bit SHALL ever be high.

Reset
REQ-024 While rstN=0 at an edge: state=IDLE, rr_ptr=0, grant=0, grant_id=0, slave_sel=0, bus_busy=0, timeout=0, hold counter=0.
REQ-025 Reset asserted during GRANT SHALL drop grant after that edge, with no RELEASE cycle.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN defined: a hold counter SHALL count cycles in GRANT from 0.
REQ-027 With ARB_TIMEOUT_EN defined, when the counter reaches MAX_HOLD-1 with req still high, the block SHALL enter RELEASE, pulse timeout for that one RELEASE cycle, and advance rr_ptr past the offender.
REQ-028 Macro ARB_TIMEOUT_EN undefined: there SHALL be no counter, timeout SHALL be constant 0, and a tenure SHALL be unbounded.

Structure
REQ-029 Package bus_pkg SHALL hold the slave_t enum (no_slave, slave_1..slave_3), the arb_state_t enum, and the master_t typedef, shared with the master/slave RTL.
REQ-030 A sub-module rr_picker SHALL perform the combinational rotate-and-priority selection (eligible vector plus pointer in, one-hot plus index out) and SHALL be the only sub-module.

Verification
REQ-031 Single request: req=01, req_slave[0]=slave_2 -> grant=01 one cycle later, slave_sel=2, bus_busy=1; req drop -> one RELEASE cycle -> IDLE.
REQ-032 Simultaneous requests, rr_ptr=0: req=11 -> master 0 granted; master 0 releases -> 2 idle cycles -> master 1 granted, slave_sel equals its target.
REQ-033 no_slave filter: req=11, req_slave={0,3} -> master 1 granted, master 0 never granted.
REQ-034 Mid-tenure change: req_slave of the granted master changes 1->3 during GRANT -> slave_sel stays 1.
REQ-035 ARB_TIMEOUT_EN, MAX_HOLD=8, req held high -> grant drops after 8 cycles, timeout=1 for 1 cycle, other pending master granted next.
REQ-036 Reset mid-grant: rstN=0 for one edge during GRANT -> all outputs 0 after that edge; after reset, rr_ptr=0 gives master 0 priority.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: bus types shared by the master, slave and arbiter RTL
package bus_pkg;
  typedef enum logic [1:0] {no_slave, slave_1, slave_2, slave_3} slave_t;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;
  typedef logic [2:0] master_t;
endpackage

// File: rtl/master_arbiter_rr_picker.sv
// rr_picker: picks the first eligible master at or after ptr, wrapping around
module rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  always_comb begin
    onehot = '0;
    idx = '0;
    any = |eligible;
    for (int k = N - 1; k >= 0; k--)
      if (eligible[(int'(ptr) + k) % N]) idx = $clog2(N)'((int'(ptr) + k) % N);
    onehot[idx] = any;
  end
endmodule

// File: rtl/master_arbiter.sv
// master_arbiter: round-robin bus arbiter with turnaround cycle; ARB_TIMEOUT_EN bounds tenure to MAX_HOLD
module master_arbiter
  import bus_pkg::*;
#(
  parameter int MASTER_COUNT   = 2,
  parameter int SLAVE_ID_WIDTH = 2,
  parameter int MAX_HOLD       = 1024
) (
  input  logic                                         clk,
  input  logic                                         rstN,
  input  logic [MASTER_COUNT-1:0]                      req,
  input  logic [MASTER_COUNT-1:0][SLAVE_ID_WIDTH-1:0]  req_slave,
  output logic [MASTER_COUNT-1:0]                      grant,
  output logic [$clog2(MASTER_COUNT)-1:0]              grant_id,
  output logic [SLAVE_ID_WIDTH-1:0]                    slave_sel,
  output logic                                         bus_busy,
  output logic                                         timeout
);
  localparam int IW = $clog2(MASTER_COUNT);
  if (MASTER_COUNT < 2 || MASTER_COUNT > 8 || MAX_HOLD < 2) begin : g_bad_cfg
    $error("master_arbiter: unsupported MASTER_COUNT or MAX_HOLD");
  end
  arb_state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gid_q, gid_d, pick_idx;
  logic [MASTER_COUNT-1:0] eligible, pick_oh, gnt_q, gnt_d;
  logic [SLAVE_ID_WIDTH-1:0] sel_q, sel_d;
  logic pick_any, expire;
  always_comb
    for (int i = 0; i < MASTER_COUNT; i++) eligible[i] = req[i] && |req_slave[i];
  rr_picker #(.N(MASTER_COUNT)) u_pick (
    .eligible(eligible),
    .ptr     (ptr_q),
    .onehot  (pick_oh),
    .idx     (pick_idx),
    .any     (pick_any)
  );
`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] cnt_q;
  logic to_q;
  assign expire = cnt_q == HW'(MAX_HOLD - 1);
  always_ff @(posedge clk)
    if (!rstN) begin
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      cnt_q <= state_q == GRANT ? cnt_q + 1'b1 : '0;
      to_q <= state_q == GRANT && expire && req[gid_q];
    end
  assign timeout = to_q;
`else
  assign expire = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rstN) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gid_q <= '0;
      gnt_q <= '0;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
    end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gid_d = gid_q;
    gnt_d = gnt_q;
    sel_d = sel_q;
    case (state_q)
      IDLE: if (pick_any) begin
        state_d = GRANT;
        gid_d = pick_idx;
        gnt_d = pick_oh;
        sel_d = req_slave[pick_idx];
      end
      GRANT: if (!req[gid_q] || expire) begin
        state_d = RELEASE;
        ptr_d = gid_q == IW'(MASTER_COUNT - 1) ? '0 : gid_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus_busy = state_q == GRANT;
  assign grant = bus_busy ? gnt_q : '0;
  assign grant_id = bus_busy ? gid_q : '0;
  assign slave_sel = bus_busy ? sel_q : '0;
endmodule

// File: tb/tb_master_arbiter.sv
// tb_master_arbiter: directed checks of grant, rotation, no_slave filter, reset and timeout
module tb_master_arbiter;
  logic clk = 1'b0, rstN = 1'b0;
  logic [1:0] req = '0;
  logic [1:0][1:0] req_slave = '0;
  logic [1:0] grant;
  logic [0:0] grant_id;
  logic [1:0] slave_sel;
  logic bus_busy, timeout;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  master_arbiter #(
    .MASTER_COUNT(2),
    .SLAVE_ID_WIDTH(2),
`ifdef ARB_TIMEOUT_EN
    .MAX_HOLD(8)
`else
    .MAX_HOLD(1024)
`endif
  ) dut (
    .clk(clk), .rstN(rstN), .req(req), .req_slave(req_slave), .grant(grant),
    .grant_id(grant_id), .slave_sel(slave_sel), .bus_busy(bus_busy), .timeout(timeout)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string tag, input int g, input int id, input int sel, input int to);
    chk({tag, ".grant"}, int'(grant), g);
    chk({tag, ".grant_id"}, int'(grant_id), id);
    chk({tag, ".slave_sel"}, int'(slave_sel), sel);
    chk({tag, ".bus_busy"}, int'(bus_busy), g != 0);
    chk({tag, ".timeout"}, int'(timeout), to);
  endtask
  initial begin
    step();
    step();
    expect_out("reset", 0, 0, 0, 0);
    rstN = 1'b1;
    // single request
    req = 2'b01;
    req_slave[0] = 2'd2;
    step();
    expect_out("single.grant", 1, 0, 2, 0);
    step();
    expect_out("single.hold", 1, 0, 2, 0);
    req = 2'b00;
    step();
    expect_out("single.release", 0, 0, 0, 0);
    step();
    expect_out("single.idle", 0, 0, 0, 0);
    // no_slave filter: master 0 targets no_slave, ptr now 1
    req = 2'b11;
    req_slave[0] = 2'd0;
    req_slave[1] = 2'd3;
    step();
    expect_out("filter.grant", 2, 1, 3, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("filter.hold", 2, 1, 3, 0);
    end
    req = 2'b01;
    step();
    expect_out("filter.release", 0, 0, 0, 0);
    step();
    expect_out("filter.idle", 0, 0, 0, 0);
    // simultaneous requests with ptr back at 0
    req = 2'b11;
    req_slave[0] = 2'd1;
    req_slave[1] = 2'd2;
    step();
    expect_out("rr.grant0", 1, 0, 1, 0);
    req_slave[0] = 2'd3;
    step();
    expect_out("midchange.sel_held", 1, 0, 1, 0);
    step();
    expect_out("nopreempt", 1, 0, 1, 0);
    req = 2'b10;
    step();
    expect_out("rr.gap1", 0, 0, 0, 0);
    step();
    expect_out("rr.gap2", 0, 0, 0, 0);
    step();
    expect_out("rr.grant1", 2, 1, 2, 0);
    // reset mid-grant, then ptr=0 must favour master 0
    req = 2'b11;
    req_slave[0] = 2'd1;
    rstN = 1'b0;
    step();
    expect_out("rstmid.drop", 0, 0, 0, 0);
    rstN = 1'b1;
    step();
    expect_out("rstmid.regrant", 1, 0, 1, 0);
    req = 2'b00;
    step();
    expect_out("rstmid.release", 0, 0, 0, 0);
    step();
    req = 2'b11;
    req_slave[0] = 2'd1;
    req_slave[1] = 2'd2;
    step();
    expect_out("hold.grant", 2, 1, 2, 0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      step();
      expect_out("hold.tenure", 2, 1, 2, 0);
    end
    step();
    expect_out("hold.timeout", 0, 0, 0, 1);
    step();
    expect_out("hold.idle", 0, 0, 0, 0);
    step();
    expect_out("hold.next", 1, 0, 1, 0);
`else
    for (int i = 0; i < 20; i++) begin
      step();
      expect_out("hold.unbounded", 2, 1, 2, 0);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
